regfile_sync_rd: RTL and testbench
==================================

REGFILE_SYNC_RD -- requirements
Module: regfile_sync_rd

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, meaning entry address width; depth = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning entry and read-data width.
REQ-003 SHALL have parameter RESET_VAL, default 0, meaning value loaded into every entry 1..depth-1 on reset.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 SHALL have port rst  input  1  synchronous active-low reset; rst=0 sampled at posedge resets.
REQ-006 SHALL have port wen  input  1  write enable.
REQ-007 SHALL have port waddr  input  ADDR_WIDTH  write address.
REQ-008 SHALL have port wdata  input  DATA_WIDTH  write data.
REQ-009 SHALL have port rd_req1 / rd_req2  input  1 each  read request, port 1 / port 2.
REQ-010 SHALL have port raddr1 / raddr2  input  ADDR_WIDTH each  read address, port 1 / port 2.
REQ-011 SHALL have port rd_valid1 / rd_valid2  output  1 each  read data valid, port 1 / port 2.
REQ-012 SHALL have port rdata1 / rdata2  output  DATA_WIDTH each  registered read data, port 1 / port 2.

Function
REQ-013 SHALL hold depth entries; entry 0 SHALL always read as 0, and writes to address 0 SHALL be discarded.
REQ-014 SHALL write wdata into entry waddr at posedge when rst=1 and wen=1; no write otherwise.
REQ-015 Read latency SHALL be exactly 1 cycle: a request sampled at edge N SHALL drive rd_validX=1 and rdataX after edge N, for one cycle.
REQ-016 rd_validX SHALL be a single-cycle pulse per accepted request; back-to-back requests SHALL give back-to-back valid cycles, one data word per cycle.
REQ-017 When rd_reqX=0, rd_validX SHALL go 0 and rdataX SHALL hold its last value.
REQ-018 Bypass: if wen=1, waddr=raddrX, waddrX!=0 and rd_reqX=1 in the same cycle, rdataX SHALL return wdata, not the stale entry.
REQ-019 Reads to address 0 SHALL return 0 even when a same-cycle write targets address 0.
REQ-020 Both ports SHALL operate independently; both SHALL be able to read the same address in the same cycle, and each SHALL get the same result.
REQ-021 The block SHALL have no internal stall and no back-pressure; every request SHALL be accepted.
REQ-022 Address arithmetic SHALL use no wrap or offset; every address value SHALL be legal.

Reset
REQ-023 On posedge with rst=0: entries 1..depth-1 SHALL become RESET_VAL, rd_valid1/2 SHALL become 0, and rdata1/2 SHALL become 0.
REQ-024 Reset SHALL dominate: with rst=0, wen and rd_reqX SHALL be ignored in that cycle, including a read or write in flight.
REQ-025 In the first cycle after rst returns to 1, the block SHALL accept requests and writes normally.

Verification
REQ-026 Bench SHALL cover reset read: hold rst=0 for 2 cycles, release, read addr 7 on port 1 -> next cycle rd_valid1=1, rdata1=RESET_VAL.
REQ-027 Bench SHALL cover write then read: write 0xDEADBEEF to addr 3, next cycle rd_req1 addr 3 -> next cycle rdata1=0xDEADBEEF, rd_valid1=1 for one cycle.
REQ-028 Bench SHALL cover bypass: in the same cycle, wen addr 5 data 0x12345678 and rd_req2 addr 5 (entry previously 0x1) -> next cycle rdata2=0x12345678.
REQ-029 Bench SHALL cover x0: write 0xFFFFFFFF to addr 0 while both ports read addr 0 -> rdata1=rdata2=0, and a later read of addr 0 also returns 0.
REQ-030 Bench SHALL cover mid-operation reset: addr 9=0xA5, rd_req1 addr 9 with rst=0 in the same cycle -> next cycle rd_valid1=0, rdata1=0, and a read of addr 9 after release returns RESET_VAL.
REQ-031 Bench SHALL cover idle hold: a read returns 0x55, then rd_req1=0 for 3 cycles -> rd_valid1=0 and rdata1 stays 0x55 throughout.

Source files
------------

// File: rtl/regfile_sync_rd.sv
// Register file with one write port and two independent registered read ports.
// Entry 0 is hard-wired to zero; reads see a same-cycle write through a bypass path.
module regfile_sync_rd #(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_req1,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic                  rd_req2,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic                  rd_valid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  rd_valid2,
  output logic [DATA_WIDTH-1:0] rdata2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];

  // Entry 0 is never written so it stays at the zero it gets on reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= (i == 0) ? '0 : RESET_VAL;
      end
    end else if (wen && (waddr != '0)) begin
      mem_reg[waddr] <= wdata;
    end
  end

  logic                  rd_req_arr   [2];
  logic [ADDR_WIDTH-1:0] raddr_arr    [2];
  logic                  rd_valid_arr [2];
  logic [DATA_WIDTH-1:0] rdata_arr    [2];

  assign rd_req_arr[0] = rd_req1;
  assign rd_req_arr[1] = rd_req2;
  assign raddr_arr[0]  = raddr1;
  assign raddr_arr[1]  = raddr2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd_port
      logic                  valid_reg;
      logic [DATA_WIDTH-1:0] data_reg;
      logic [DATA_WIDTH-1:0] data_next;

      // Address 0 wins over the bypass so a discarded write never leaks out.
      always_comb begin
        data_next = mem_reg[raddr_arr[gi]];
        if (raddr_arr[gi] == '0) begin
          data_next = '0;
        end else if (wen && (waddr == raddr_arr[gi])) begin
          data_next = wdata;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end else begin
          valid_reg <= rd_req_arr[gi];
          if (rd_req_arr[gi]) begin
            data_reg <= data_next;
          end
        end
      end

      assign rd_valid_arr[gi] = valid_reg;
      assign rdata_arr[gi]    = data_reg;
    end
  endgenerate

  assign rd_valid1 = rd_valid_arr[0];
  assign rdata1    = rdata_arr[0];
  assign rd_valid2 = rd_valid_arr[1];
  assign rdata2    = rdata_arr[1];

endmodule

// File: tb/tb_regfile_sync_rd.sv
// Scoreboard bench for regfile_sync_rd: directed scenarios followed by random traffic,
// expected responses come from an array-based model of the register file.
module tb_regfile_sync_rd;

  localparam int          AW   = 5;
  localparam int          DW   = 32;
  localparam int          DEP  = 2 ** AW;
  localparam logic [31:0] RVAL = 32'hC0DE_0001;

  logic          clk = 1'b0;
  logic          rst;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          rd_req1, rd_req2;
  logic [AW-1:0] raddr1, raddr2;
  logic          rd_valid1, rd_valid2;
  logic [DW-1:0] rdata1, rdata2;

  regfile_sync_rd #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .RESET_VAL (RVAL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wen      (wen),
    .waddr    (waddr),
    .wdata    (wdata),
    .rd_req1  (rd_req1),
    .raddr1   (raddr1),
    .rd_req2  (rd_req2),
    .raddr2   (raddr2),
    .rd_valid1(rd_valid1),
    .rdata1   (rdata1),
    .rd_valid2(rd_valid2),
    .rdata2   (rdata2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v1;
    logic [31:0] d1;
    logic        v2;
    logic [31:0] d2;
    int          tag;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_mem [DEP];
  logic [31:0] last1 = '0;
  logic [31:0] last2 = '0;
  int          total = 0;
  int          bad   = 0;
  int          txn   = 0;

  function automatic logic [31:0] model_read(input logic [AW-1:0] a, input logic w,
                                             input logic [AW-1:0] wa, input logic [31:0] wd);
    if (a == 0) return 32'h0;
    if (w && wa == a) return wd;
    return model_mem[a];
  endfunction

  // Drive one cycle of stimulus and record what the DUT must show after the next edge.
  task automatic drive(input logic r, input logic w, input logic [AW-1:0] wa,
                       input logic [31:0] wd, input logic q1, input logic [AW-1:0] a1,
                       input logic q2, input logic [AW-1:0] a2, input int tag);
    exp_t e;
    @(negedge clk);
    #1;
    rst = r; wen = w; waddr = wa; wdata = wd;
    rd_req1 = q1; raddr1 = a1; rd_req2 = q2; raddr2 = a2;
    e.tag = tag;
    if (!r) begin
      for (int i = 0; i < DEP; i++) model_mem[i] = (i == 0) ? 32'h0 : RVAL;
      last1 = '0; last2 = '0;
      e.v1 = 0; e.d1 = 0; e.v2 = 0; e.d2 = 0;
    end else begin
      if (q1) last1 = model_read(a1, w, wa, wd);
      if (q2) last2 = model_read(a2, w, wa, wd);
      e.v1 = q1; e.d1 = last1; e.v2 = q2; e.d2 = last2;
      if (w && wa != 0) model_mem[wa] = wd;
    end
    sb_q.push_back(e);
  endtask

  task automatic idle(input int tag);
    drive(1, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp,
                       input int tag);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s tag=%0d txn=%0d got=%h exp=%h", name, tag, txn, got, exp);
    end
  endtask

  // Monitor: every cycle after stimulus has been issued, compare DUT outputs to the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        txn++;
        $display("txn %0d tag=%0d v1=%0b d1=%h v2=%0b d2=%h", txn, e.tag,
                 rd_valid1, rdata1, rd_valid2, rdata2);
        check("rd_valid1", {31'b0, rd_valid1}, {31'b0, e.v1}, e.tag);
        check("rdata1", rdata1, e.d1, e.tag);
        check("rd_valid2", {31'b0, rd_valid2}, {31'b0, e.v2}, e.tag);
        check("rdata2", rdata2, e.d2, e.tag);
      end
    end
  end

  initial begin
    int wait_cycles;
    rst = 1; wen = 0; waddr = 0; wdata = 0;
    rd_req1 = 0; raddr1 = 0; rd_req2 = 0; raddr2 = 0;
    for (int i = 0; i < DEP; i++) model_mem[i] = 32'h0;

    // Reset read
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 1, 7, 0, 0, 1);
    // Write then read, single-cycle valid
    drive(1, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 2);
    drive(1, 0, 0, 0, 1, 3, 0, 0, 2);
    idle(2);
    // Bypass on port 2
    drive(1, 1, 5, 32'h1, 0, 0, 0, 0, 3);
    drive(1, 1, 5, 32'h12345678, 0, 0, 1, 5, 3);
    drive(1, 0, 0, 0, 0, 0, 1, 5, 3);
    // Entry 0 stays zero
    drive(1, 1, 0, 32'hFFFFFFFF, 1, 0, 1, 0, 4);
    drive(1, 0, 0, 0, 1, 0, 1, 0, 4);
    // Reset in the middle of a read
    drive(1, 1, 9, 32'hA5, 0, 0, 0, 0, 5);
    drive(0, 1, 9, 32'h77, 1, 9, 1, 9, 5);
    drive(1, 0, 0, 0, 1, 9, 0, 0, 5);
    // Idle hold
    drive(1, 1, 4, 32'h55, 0, 0, 0, 0, 6);
    drive(1, 0, 0, 0, 1, 4, 0, 0, 6);
    idle(6); idle(6); idle(6);
    // Same address on both ports, back-to-back reads
    drive(1, 1, 12, 32'hCAFEF00D, 1, 12, 1, 12, 7);
    drive(1, 0, 0, 0, 1, 12, 1, 12, 7);
    drive(1, 1, 12, 32'h0BADBEEF, 1, 12, 1, 3, 7);

    // Random traffic, addresses biased low so bypass and collisions happen often
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] wa, a1, a2;
      wa = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, DEP - 1) : $urandom_range(0, 7));
      a1 = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, DEP - 1) : $urandom_range(0, 7));
      a2 = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, DEP - 1) : $urandom_range(0, 7));
      drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 1) == 1), wa, $urandom,
            ($urandom_range(0, 3) != 0), a1, ($urandom_range(0, 3) != 0), a2, 8);
    end

    wait_cycles = 0;
    while (sb_q.size() != 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    #2;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d exp=0 pending entries", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
